// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one registered FIFO write port
// between NUM_REQ streaming requesters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IF_WIDTH  = 256,
  parameter int BURST_LEN = 16,
  parameter int ID_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*IF_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [IF_WIDTH-1:0]          fifo_b_wrdata,
  output logic                         fifo_b_wren,
  input  logic                         fifo_b_full,
  input  logic                         fifo_b_almostfull,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy
);
  localparam int CNT_W = $clog2(BURST_LEN);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                            state, state_nxt;
  logic [ID_W-1:0]                   rr_ptr, rr_nxt, pick, idx;
  logic                              pick_vld;
  logic [CNT_W-1:0]                  beat_cnt;
  logic                              space, g_valid, g_last, xfer, burst_end;
  logic [NUM_REQ-1:0][IF_WIDTH-1:0]  req_lane;
  int unsigned                       cand;

  assign req_lane  = req_data;
  assign busy      = (state == BURST);
  // Stopping on almostfull keeps the one in-flight registered write legal.
  assign space     = !fifo_b_full && !fifo_b_almostfull;
  assign g_valid   = req_valid[grant_id];
  assign g_last    = req_last[grant_id];
  assign xfer      = busy && space && g_valid;
  assign burst_end = (xfer && (g_last || beat_cnt == CNT_W'(BURST_LEN-1))) ||
                     (busy && !g_valid);
  assign rr_nxt    = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req_ready[i] = busy && space && (grant_id == ID_W'(i));
  end

  // Scan from the highest offset down so the candidate nearest rr_ptr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = 0;
    idx      = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      idx  = ID_W'(cand);
      if (req_valid[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld)  state_nxt = BURST;
      BURST:   if (burst_end) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_b_wren   <= 1'b0;
      fifo_b_wrdata <= '0;
      grant_id      <= '0;
      rr_ptr        <= '0;
      beat_cnt      <= '0;
    end else begin
      fifo_b_wren <= xfer;
      if (xfer) begin
        fifo_b_wrdata <= req_lane[grant_id];
        beat_cnt      <= beat_cnt + CNT_W'(1);
      end
      if (state == IDLE && pick_vld) begin
        grant_id <= pick;
        beat_cnt <= '0;
      end
      if (burst_end) rr_ptr <= rr_nxt;
    end
  end
endmodule
